// File: rtl/cache_fill_pkg.sv
// Shared types and constants for the L2 miss-fill path.
// State encoding, word geometry, error pattern and width helpers.
package cache_fill_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } fill_state_e;

  localparam int WORD_BYTES = 4;
  localparam logic [31:0] MISS_PATTERN = 32'hD00DFEED;

  function automatic int beats_f(input int block_bytes);
    return block_bytes / WORD_BYTES;
  endfunction

  function automatic int idx_w_f(input int block_bytes);
    return $clog2(block_bytes / WORD_BYTES);
  endfunction

  function automatic int wsel_w_f();
    return $clog2(WORD_BYTES);
  endfunction

endpackage

// File: rtl/miss_fill_controller_wrap_beat_counter.sv
// Critical-word-first beat sequencer for one L2 block.
// Ports: load_i/word_addr_i capture a miss, adv_i steps one beat;
// nxt_addr_o is the following beat address, first_o/last_o flag the
// beat position, l1_o marks beats in the requested word's L1 half.
module wrap_beat_counter
  import cache_fill_pkg::*;
#(
  parameter int ADDR_WIDTH    = 11,
  parameter int BLOCK_SIZE    = 32,
  parameter int L1_BLOCK_SIZE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-3:0] word_addr_i,
  input  logic                  adv_i,
  output logic [ADDR_WIDTH-1:0] nxt_addr_o,
  output logic                  first_o,
  output logic                  last_o,
  output logic                  l1_o
);

  localparam int BEATS = beats_f(BLOCK_SIZE);
  localparam int IW    = idx_w_f(BLOCK_SIZE);
  localparam int WB    = wsel_w_f();
  localparam int OW    = IW + WB;
  localparam int BW    = ADDR_WIDTH - OW;
  // L1 half-select bit, expressed as a word-address bit
  localparam int HB    = $clog2(L1_BLOCK_SIZE) - WB;

  logic [BW-1:0] base_q, base_d;
  logic [IW-1:0] start_q, start_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;
  logic [IW-1:0] idx, nidx;
  logic [ADDR_WIDTH-3:0] beat_waddr;

  always_comb begin
    base_d  = base_q;
    start_d = start_q;
    cnt_d   = cnt_q;
    half_d  = half_q;
    if (load_i) begin
      base_d  = word_addr_i[ADDR_WIDTH-3:IW];
      start_d = word_addr_i[IW-1:0];
      cnt_d   = '0;
      half_d  = word_addr_i[HB];
    end else if (adv_i) begin
      cnt_d = cnt_q + IW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q  <= '0;
      start_q <= '0;
      cnt_q   <= '0;
      half_q  <= 1'b0;
    end else begin
      base_q  <= base_d;
      start_q <= start_d;
      cnt_q   <= cnt_d;
      half_q  <= half_d;
    end
  end

  // index arithmetic is IW bits wide, so wrap is free
  assign idx        = start_q + cnt_q;
  assign nidx       = idx + IW'(1);
  assign beat_waddr = {base_q, idx};
  assign nxt_addr_o = {base_q, nidx, {WB{1'b0}}};
  assign first_o    = (cnt_q == '0);
  assign last_o     = (cnt_q == IW'(BEATS - 1));
  assign l1_o       = (beat_waddr[HB] == half_q);

endmodule

// File: rtl/miss_fill_controller.sv
// Miss fill controller: fetches a full L2 block critical word first,
// returns the requested word, streams fill beats to L2/L1.
// Ports: miss_* request in, mem_* beat handshake, resp_* critical word,
// fill_* per-beat fill plus done/abort pulses. All outputs registered.
module miss_fill_controller
  import cache_fill_pkg::*;
#(
  parameter int ADDR_WIDTH     = 11,
  parameter int DATA_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 32,
  parameter int L1_BLOCK_SIZE  = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [DATA_WIDTH-1:0] MISS_PATTERN =
    DATA_WIDTH'(cache_fill_pkg::MISS_PATTERN)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  miss_ready,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_err,
  output logic                  fill_valid,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_l1,
  output logic                  fill_done,
  output logic                  fill_abort
);

  localparam int WB = wsel_w_f();
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  fill_state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic                  miss_ready_q, miss_ready_d;
  logic                  mem_req_q, mem_req_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  resp_err_q, resp_err_d;
  logic                  fill_valid_q, fill_valid_d;
  logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
  logic [DATA_WIDTH-1:0] fill_data_q, fill_data_d;
  logic                  fill_l1_q, fill_l1_d;
  logic                  fill_done_q, fill_done_d;
  logic                  fill_abort_q, fill_abort_d;

  logic                  ack;
  logic                  load;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic                  beat_first;
  logic                  beat_last;
  logic                  beat_l1;
  logic                  unused_lo;

  // acks only count while a beat is actually being requested
  assign ack  = mem_req_q & mem_ack;
  assign load = (state_q == IDLE) & miss_valid;

  // byte offset within the word never affects the fetch
  assign unused_lo = ^miss_addr[WB-1:0];

  wrap_beat_counter #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .BLOCK_SIZE    (BLOCK_SIZE),
    .L1_BLOCK_SIZE (L1_BLOCK_SIZE)
  ) u_beat (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .word_addr_i (miss_addr[ADDR_WIDTH-1:WB]),
    .adv_i       (ack),
    .nxt_addr_o  (nxt_addr),
    .first_o     (beat_first),
    .last_o      (beat_last),
    .l1_o        (beat_l1)
  );

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    mem_addr_d   = mem_addr_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_err_d   = 1'b0;
    fill_valid_d = 1'b0;
    fill_addr_d  = fill_addr_q;
    fill_data_d  = fill_data_q;
    fill_l1_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (miss_valid) begin
          state_d    = FETCH;
          mem_addr_d = {miss_addr[ADDR_WIDTH-1:WB], {WB{1'b0}}};
        end
      end
      FETCH: begin
        if (ack) begin
          tmo_d        = '0;
          fill_valid_d = 1'b1;
          fill_addr_d  = mem_addr_q;
          fill_data_d  = mem_rdata;
          fill_l1_d    = beat_l1;
          if (beat_first) begin
            resp_valid_d = 1'b1;
            resp_data_d  = mem_rdata;
          end
          if (beat_last) begin
            state_d = DONE;
          end else begin
            mem_addr_d = nxt_addr;
          end
        end else begin
          tmo_d = (tmo_q == TMAX) ? TMAX : tmo_q + TW'(1);
          if (tmo_d == TMAX) begin
            state_d = ERR;
            // critical word never arrived: answer with the error pattern
            if (beat_first) begin
              resp_valid_d = 1'b1;
              resp_err_d   = 1'b1;
              resp_data_d  = MISS_PATTERN;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // registered Moore outputs track the state being entered
    miss_ready_d = (state_d == IDLE);
    mem_req_d    = (state_d == FETCH);
    fill_done_d  = (state_d == DONE);
    fill_abort_d = (state_d == ERR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      miss_ready_q <= 1'b1;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_addr_q  <= '0;
      fill_data_q  <= '0;
      fill_l1_q    <= 1'b0;
      fill_done_q  <= 1'b0;
      fill_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      miss_ready_q <= miss_ready_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      fill_valid_q <= fill_valid_d;
      fill_addr_q  <= fill_addr_d;
      fill_data_q  <= fill_data_d;
      fill_l1_q    <= fill_l1_d;
      fill_done_q  <= fill_done_d;
      fill_abort_q <= fill_abort_d;
    end
  end

  assign miss_ready = miss_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign fill_valid = fill_valid_q;
  assign fill_addr  = fill_addr_q;
  assign fill_data  = fill_data_q;
  assign fill_l1    = fill_l1_q;
  assign fill_done  = fill_done_q;
  assign fill_abort = fill_abort_q;

endmodule
